// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED mode sequencer: mode encodings, per-mode
// LED start values and small pattern helpers.
package led_seq_pkg;

  localparam int LED_W = 8;

  typedef enum logic [1:0] {
    MODE_SCAN  = 2'd0,
    MODE_FILL  = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_OFF   = 2'd3
  } mode_e;

  localparam logic [LED_W-1:0] START_SCAN  = 8'h01;
  localparam logic [LED_W-1:0] START_FILL  = 8'h00;
  localparam logic [LED_W-1:0] START_BLINK = 8'hFF;
  localparam logic [LED_W-1:0] START_OFF   = 8'h00;

  function automatic logic [LED_W-1:0] start_leds(input mode_e m);
    logic [LED_W-1:0] v;
    case (m)
      MODE_SCAN:  v = START_SCAN;
      MODE_FILL:  v = START_FILL;
      MODE_BLINK: v = START_BLINK;
      MODE_OFF:   v = START_OFF;
      default:    v = START_OFF;
    endcase
    return v;
  endfunction

  function automatic logic [LED_W-1:0] onehot(input logic [2:0] pos);
    logic [LED_W-1:0] v;
    v      = '0;
    v[pos] = 1'b1;
    return v;
  endfunction

  // Level 0..8 maps to the lowest `level` LEDs lit; level 8 lights all.
  function automatic logic [LED_W-1:0] fill_mask(input logic [3:0] level);
    logic [LED_W:0] v;
    v = {{LED_W{1'b0}}, 1'b1} << level;
    v = v - 1'b1;
    return v[LED_W-1:0];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a level debouncer: the output level only
// follows the synchronized input after DEB_CYCLES consecutive mismatching clocks.
module btn_debounce #(
  parameter int DEB_CYCLES = 65536
) (
  input  logic clki,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clki or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
      // Any cycle where input agrees with the accepted level restarts the count.
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign dout = r_level;

endmodule

// File: rtl/led_mode_sequencer.sv
// Button-selected LED pattern sequencer (SCAN/FILL/BLINK/OFF) stepped by a
// prescaler tick. Define LED_SEQ_TRAIL_EN to add a dim trailing LED in SCAN.
module led_mode_sequencer
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV   = 8388608,
  parameter int DEB_CYCLES = 65536
) (
  input  logic             clki,
  input  logic             reset,
  input  logic             btn_next,
  input  logic             pause,
  output logic [LED_W-1:0] leds,
  output logic [1:0]       mode
);

  localparam int PRES_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRES_W-1:0] PRES_LAST = PRES_W'(TICK_DIV - 1);

  mode_e             r_mode;
  logic [LED_W-1:0]  r_leds;
  logic [2:0]        r_pos;
  logic              r_dir_up;
  logic [3:0]        r_level;
  logic [PRES_W-1:0] r_pres;
  logic              r_deb_d;

  mode_e             w_mode_nxt;
  logic [LED_W-1:0]  w_leds_nxt;
  logic [2:0]        w_pos_nxt;
  logic              w_dir_nxt;
  logic [3:0]        w_level_nxt;
  logic [PRES_W-1:0] w_pres_nxt;
  logic              w_deb;
  logic              w_adv;
  logic              w_tick;

`ifdef LED_SEQ_TRAIL_EN
  logic [1:0] r_pwm;
  logic [2:0] r_prev;
  logic       r_trail;
  logic [1:0] w_pwm_nxt;
  logic [2:0] w_prev_nxt;
  logic       w_trail_nxt;
`endif

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn_debounce (
    .clki (clki),
    .reset(reset),
    .din  (btn_next),
    .dout (w_deb)
  );

  assign w_adv  = w_deb & ~r_deb_d;
  assign w_tick = ~pause & (r_pres == PRES_LAST);

  // Mode advance takes priority: it reloads the pattern and swallows a same-cycle tick.
  always_comb begin
    w_mode_nxt  = r_mode;
    w_leds_nxt  = r_leds;
    w_pos_nxt   = r_pos;
    w_dir_nxt   = r_dir_up;
    w_level_nxt = r_level;
    w_pres_nxt  = r_pres;
    if (w_adv) begin
      w_mode_nxt  = mode_e'(r_mode + 2'd1);
      w_leds_nxt  = start_leds(w_mode_nxt);
      w_pos_nxt   = 3'd0;
      w_dir_nxt   = 1'b1;
      w_level_nxt = 4'd0;
      w_pres_nxt  = '0;
    end else if (!pause) begin
      w_pres_nxt = w_tick ? '0 : r_pres + 1'b1;
      if (w_tick) begin
        case (r_mode)
          MODE_SCAN: begin
            if (r_dir_up) begin
              if (r_pos == 3'd7) begin
                w_pos_nxt = 3'd6;
                w_dir_nxt = 1'b0;
              end else begin
                w_pos_nxt = r_pos + 3'd1;
              end
            end else begin
              if (r_pos == 3'd0) begin
                w_pos_nxt = 3'd1;
                w_dir_nxt = 1'b1;
              end else begin
                w_pos_nxt = r_pos - 3'd1;
              end
            end
            w_leds_nxt = onehot(w_pos_nxt);
          end
          MODE_FILL: begin
            w_level_nxt = (r_level == 4'd8) ? 4'd0 : r_level + 4'd1;
            w_leds_nxt  = fill_mask(w_level_nxt);
          end
          MODE_BLINK: w_leds_nxt = ~r_leds;
          MODE_OFF:   w_leds_nxt = START_OFF;
          default:    w_leds_nxt = START_OFF;
        endcase
      end
    end
`ifdef LED_SEQ_TRAIL_EN
    w_pwm_nxt   = r_pwm + 2'd1;
    w_prev_nxt  = r_prev;
    w_trail_nxt = r_trail;
    if (w_adv) begin
      w_trail_nxt = 1'b0;
    end else if (w_tick && (r_mode == MODE_SCAN)) begin
      w_prev_nxt  = r_pos;
      w_trail_nxt = 1'b1;
    end
    // SCAN output is rebuilt every clock so the trail follows the PWM phase.
    if (w_mode_nxt == MODE_SCAN) begin
      w_leds_nxt = onehot(w_pos_nxt) |
                   ((w_trail_nxt && (w_pwm_nxt == 2'd0)) ? onehot(w_prev_nxt) : '0);
    end
`endif
  end

  always_ff @(posedge clki or negedge reset) begin
    if (!reset) begin
      r_mode   <= MODE_SCAN;
      r_leds   <= START_SCAN;
      r_pos    <= 3'd0;
      r_dir_up <= 1'b1;
      r_level  <= 4'd0;
      r_pres   <= '0;
      r_deb_d  <= 1'b0;
`ifdef LED_SEQ_TRAIL_EN
      r_pwm    <= 2'd0;
      r_prev   <= 3'd0;
      r_trail  <= 1'b0;
`endif
    end else begin
      r_mode   <= w_mode_nxt;
      r_leds   <= w_leds_nxt;
      r_pos    <= w_pos_nxt;
      r_dir_up <= w_dir_nxt;
      r_level  <= w_level_nxt;
      r_pres   <= w_pres_nxt;
      r_deb_d  <= w_deb;
`ifdef LED_SEQ_TRAIL_EN
      r_pwm    <= w_pwm_nxt;
      r_prev   <= w_prev_nxt;
      r_trail  <= w_trail_nxt;
`endif
    end
  end

  assign leds = r_leds;
  assign mode = r_mode;

endmodule
